// File: rtl/chip8_sprite_drawer_pkg.sv
// Shared definitions for the CHIP-8 sprite drawer.
// Holds the default screen geometry, the memory-region selector codes used on
// the arbiter request port, the draw FSM state type and the sprite mask helpers.
package chip8_sprite_drawer_pkg;

  localparam int DEF_SCREEN_W = 64;
  localparam int DEF_SCREEN_H = 32;
  localparam int VRAM_DEPTH   = DEF_SCREEN_W * DEF_SCREEN_H / 8;

  localparam logic MEM_TYPE_RAM  = 1'b0;
  localparam logic MEM_TYPE_VRAM = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    RD_SPR,
    WT_SPR,
    RD_L,
    WT_L,
    WR_L,
    RD_R,
    WT_R,
    WR_R,
    NEXT,
    DONE
  } sprite_state_t;

  // Part of the sprite row landing in the left VRAM byte.
  function automatic logic [7:0] mask_left(input logic [7:0] spr, input logic [2:0] off);
    return spr >> off;
  endfunction

  // Part of the sprite row spilling into the next VRAM byte, i.e. spr << (8 - off)
  // truncated to a byte; shifting the byte-extended row right avoids a 4-bit amount.
  function automatic logic [7:0] mask_right(input logic [7:0] spr, input logic [2:0] off);
    logic [15:0] wide;
    wide = {spr, 8'h00} >> off;
    return wide[7:0];
  endfunction

endpackage

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN draw engine on the video request port of the memory arbiter.
// Fetches N sprite rows from RAM at I, XORs each into VRAM with a read-modify-write
// of one or two bytes per row, and reports whether any lit pixel was cleared.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   start_in, x_in, y_in, n_in,   draw command (sampled only while idle)
//   i_in
//   busy_out, done_out,            status towards the processor FSM
//   collision_out
//   mem_valid_out, mem_ready_in,   single-outstanding request port
//   mem_we_out, mem_type_out,
//   mem_addr_out, mem_data_out
//   mem_rvalid_in, mem_rdata_in    read response
module chip8_sprite_drawer
  import chip8_sprite_drawer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [7:0]       x_in,
  input  logic [7:0]       y_in,
  input  logic [3:0]       n_in,
  input  logic [11:0]      i_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             collision_out,
  output logic             mem_valid_out,
  input  logic             mem_ready_in,
  output logic             mem_we_out,
  output logic             mem_type_out,
  output logic [15:0]      mem_addr_out,
  output logic [WIDTH-1:0] mem_data_out,
  input  logic             mem_rvalid_in,
  input  logic [WIDTH-1:0] mem_rdata_in
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int YE = YW + 1;
  localparam int BW = XW - 3;

  sprite_state_t state, state_nxt;

  logic [XW-1:0]    x0;
  logic [YW-1:0]    y0;
  logic [3:0]       n;
  logic [11:0]      i_base;
  logic [3:0]       row;
  logic [WIDTH-1:0] spr;
  logic [WIDTH-1:0] old;
  logic             coll;

  // One extra bit so rows falling off the bottom are detected instead of wrapping.
  logic [YE-1:0]    y_cur;
  logic [YE-1:0]    y_nxt;
  logic [2:0]       off;
  logic [BW-1:0]    bx;
  logic [YW+BW-1:0] idx_l;
  logic [YW+BW-1:0] idx_r;
  logic [WIDTH-1:0] mask_l;
  logic [WIDTH-1:0] mask_r;
  logic             right_en;
  logic             row_last;
  logic             accept;
  logic             start_ok;
  logic             unused_bits;

  assign unused_bits = ^{x_in[7:XW], y_in[7:YW], y_cur[YW]};

  assign off      = x0[2:0];
  assign bx       = x0[XW-1:3];
  assign y_cur    = YE'(y0) + YE'(row);
  assign y_nxt    = y_cur + YE'(1);
  assign idx_l    = {y_cur[YW-1:0], bx};
  assign idx_r    = {y_cur[YW-1:0], BW'(bx + BW'(1))};
  assign mask_l   = mask_left(spr, off);
  assign mask_r   = mask_right(spr, off);
  // No wrap to the left edge: the rightmost column byte never spills.
  assign right_en = (off != 3'd0) && (bx != '1);
  assign row_last = (4'(row + 4'd1) == n) || (y_nxt >= YE'(SCREEN_H));
  assign accept   = mem_valid_out && mem_ready_in;
  assign start_ok = (state == IDLE) && start_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = (n_in == 4'd0) ? DONE : RD_SPR;
      RD_SPR:  if (accept) state_nxt = WT_SPR;
      WT_SPR:  if (mem_rvalid_in) state_nxt = RD_L;
      RD_L:    if (accept) state_nxt = WT_L;
      WT_L:    if (mem_rvalid_in) state_nxt = WR_L;
      WR_L:    if (accept) state_nxt = right_en ? RD_R : NEXT;
      RD_R:    if (accept) state_nxt = WT_R;
      WT_R:    if (mem_rvalid_in) state_nxt = WR_R;
      WR_R:    if (accept) state_nxt = NEXT;
      NEXT:    state_nxt = row_last ? DONE : RD_SPR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields derive only from registers that are frozen while a request
  // waits, so they stay stable until the arbiter accepts.
  always_comb begin
    mem_valid_out = 1'b0;
    mem_we_out    = 1'b0;
    mem_type_out  = MEM_TYPE_RAM;
    mem_addr_out  = 16'h0000;
    mem_data_out  = '0;
    done_out      = 1'b0;
    busy_out      = (state != IDLE);
    case (state)
      RD_SPR: begin
        mem_valid_out = 1'b1;
        mem_addr_out  = 16'(12'(i_base + 12'(row)));
      end
      RD_L: begin
        mem_valid_out = 1'b1;
        mem_type_out  = MEM_TYPE_VRAM;
        mem_addr_out  = 16'(idx_l);
      end
      WR_L: begin
        mem_valid_out = 1'b1;
        mem_we_out    = 1'b1;
        mem_type_out  = MEM_TYPE_VRAM;
        mem_addr_out  = 16'(idx_l);
        mem_data_out  = old ^ mask_l;
      end
      RD_R: begin
        mem_valid_out = 1'b1;
        mem_type_out  = MEM_TYPE_VRAM;
        mem_addr_out  = 16'(idx_r);
      end
      WR_R: begin
        mem_valid_out = 1'b1;
        mem_we_out    = 1'b1;
        mem_type_out  = MEM_TYPE_VRAM;
        mem_addr_out  = 16'(idx_r);
        mem_data_out  = old ^ mask_r;
      end
      DONE:    done_out = 1'b1;
      default: ;
    endcase
  end

  // Command latch and read capture (data only, no reset)
  always_ff @(posedge clk_in) begin
    if (start_ok) begin
      x0     <= x_in[XW-1:0];
      y0     <= y_in[YW-1:0];
      n      <= n_in;
      i_base <= i_in;
    end
    if (state == WT_SPR && mem_rvalid_in) spr <= mem_rdata_in;
    if ((state == WT_L || state == WT_R) && mem_rvalid_in) old <= mem_rdata_in;
  end

  // Row progress and collision tracking
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      row           <= 4'd0;
      coll          <= 1'b0;
      collision_out <= 1'b0;
    end else begin
      if (start_ok) begin
        row           <= 4'd0;
        coll          <= 1'b0;
        collision_out <= 1'b0;
      end
      if (state == NEXT) row <= row + 4'd1;
      if (state == WR_L && accept) coll <= coll | (|(old & mask_l));
      if (state == WR_R && accept) coll <= coll | (|(old & mask_r));
      // Published on entry to DONE so it is already valid alongside done_out.
      if (state_nxt == DONE) collision_out <= (state == IDLE) ? 1'b0 : coll;
    end
  end

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
module tb_chip8_sprite_drawer;
  import chip8_sprite_drawer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x, y;
  logic [3:0]  n;
  logic [11:0] i;
  logic        busy, done, coll;
  logic        mv, mr, mwe, mtype;
  logic [15:0] maddr;
  logic [7:0]  mdata;
  logic        mrv;
  logic [7:0]  mrd;

  logic        stall = 1'b0;
  logic        stray = 1'b0;
  logic        rv_r = 1'b0;
  logic [7:0]  rd_r = 8'h00;
  logic [7:0]  rd_pend = 8'h00;
  int          rcnt = 0;
  bit   [7:0]  ram  [4096];
  bit   [7:0]  vram [VRAM_DEPTH];

  always #5 clk = ~clk;

  assign mr  = ~stall;
  assign mrv = rv_r | stray;
  assign mrd = stray ? 8'h55 : rd_r;

  chip8_sprite_drawer dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .x_in          (x),
    .y_in          (y),
    .n_in          (n),
    .i_in          (i),
    .busy_out      (busy),
    .done_out      (done),
    .collision_out (coll),
    .mem_valid_out (mv),
    .mem_ready_in  (mr),
    .mem_we_out    (mwe),
    .mem_type_out  (mtype),
    .mem_addr_out  (maddr),
    .mem_data_out  (mdata),
    .mem_rvalid_in (mrv),
    .mem_rdata_in  (mrd)
  );

  // Arbiter / memory model: writes land on acceptance, reads answer a cycle later.
  always @(posedge clk) begin
    rv_r <= 1'b0;
    if (rcnt == 1) begin
      rv_r <= 1'b1;
      rd_r <= rd_pend;
    end
    if (rcnt > 0) rcnt <= rcnt - 1;
    if (mv && mr) begin
      if (mwe) vram[maddr[7:0]] <= mdata;
      else begin
        rd_pend <= mtype ? vram[maddr[7:0]] : ram[maddr[11:0]];
        rcnt    <= 1;
      end
    end
  end

  typedef struct {
    bit          is_done;
    bit          we;
    bit          typ;
    logic [15:0] addr;
    logic [7:0]  data;
    bit          coll;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req;
  } obs_t;

  exp_t sb[$];
  obs_t oq[$];
  exp_t e;
  obs_t o;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: all comparisons happen here.
  always @(negedge clk) begin
    while (oq.size() > 0) begin
      o = oq.pop_front();
      vectors++;
      if (o.act !== o.req) begin
        miscompares++;
        $display("FAIL %s: got %0h, want %0h", o.name, o.act, o.req);
      end
    end
    if (!rst && mv && mr) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_req: got we=%0b type=%0b addr=%0h data=%0h, want nothing",
                 mwe, mtype, maddr, mdata);
      end else begin
        e = sb.pop_front();
        if (e.is_done || mwe !== e.we || mtype !== e.typ || maddr !== e.addr ||
            (e.we && mdata !== e.data)) begin
          miscompares++;
          $display("FAIL mem_req: got we=%0b type=%0b addr=%0h data=%0h, want done=%0b we=%0b type=%0b addr=%0h data=%0h",
                   mwe, mtype, maddr, mdata, e.is_done, e.we, e.typ, e.addr, e.data);
        end
      end
    end
    if (!rst && done) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got done coll=%0b, want nothing", coll);
      end else begin
        e = sb.pop_front();
        if (!e.is_done || coll !== e.coll) begin
          miscompares++;
          $display("FAIL done: got done coll=%0b, want done=%0b coll=%0b addr=%0h",
                   coll, e.is_done, e.coll, e.addr);
        end
      end
    end
  end

  task automatic exp_rd(input bit typ, input logic [15:0] a);
    sb.push_back('{1'b0, 1'b0, typ, a, 8'h00, 1'b0});
  endtask

  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
    sb.push_back('{1'b0, 1'b1, 1'b1, a, d, 1'b0});
  endtask

  task automatic exp_done(input bit c);
    sb.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, c});
  endtask

  task automatic obs(input string nm, input logic [31:0] act, input logic [31:0] req);
    oq.push_back('{nm, act, req});
  endtask

  task automatic start_draw(input logic [7:0] xv, input logic [7:0] yv,
                            input logic [3:0] nv, input logic [11:0] iv);
    @(posedge clk); #1;
    x = xv; y = yv; n = nv; i = iv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) obs("timeout_done", 32'd0, 32'd1);
  endtask

  task automatic wait_req(input bit we_v, input bit typ);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mv && mwe == we_v && mtype == typ) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) obs("timeout_req", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int vcnt;
    rst = 1'b1; start = 1'b0; x = 8'd0; y = 8'd0; n = 4'd0; i = 12'd0;
    ram[12'h200] = 8'hF0;
    ram[12'h210] = 8'hFF;
    ram[12'h220] = 8'hFF; ram[12'h221] = 8'hFF; ram[12'h222] = 8'hFF;
    ram[12'h230] = 8'h81;
    ram[12'h240] = 8'hAA;
    ram[12'h250] = 8'hC3;

    repeat (3) @(posedge clk);
    #1;
    obs("rst_busy", busy, 0);
    obs("rst_done", done, 0);
    obs("rst_coll", coll, 0);
    obs("rst_valid", mv, 0);
    obs("rst_we", mwe, 0);
    obs("rst_addr", maddr, 0);
    obs("rst_data", mdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: n = 0 finishes without memory traffic
    exp_done(1'b0);
    start_draw(8'd5, 8'd5, 4'd0, 12'h300);
    lat = 0; vcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mv) vcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    obs("t1_done_within_2", (lat >= 1 && lat <= 2) ? 1 : 0, 1);
    obs("t1_no_mem_valid", vcnt, 0);

    // 2: aligned byte, no right half
    exp_rd(MEM_TYPE_RAM, 16'h0200);
    exp_rd(MEM_TYPE_VRAM, 16'd1);
    exp_wr(16'd1, 8'hF0);
    exp_done(1'b0);
    start_draw(8'd8, 8'd0, 4'd1, 12'h200);
    wait_done(100);

    // 3: straddling byte, then redraw erases and collides
    exp_rd(MEM_TYPE_RAM, 16'h0210);
    exp_rd(MEM_TYPE_VRAM, 16'd16);
    exp_wr(16'd16, 8'h1F);
    exp_rd(MEM_TYPE_VRAM, 16'd17);
    exp_wr(16'd17, 8'hE0);
    exp_done(1'b0);
    start_draw(8'd3, 8'd2, 4'd1, 12'h210);
    wait_done(100);
    exp_rd(MEM_TYPE_RAM, 16'h0210);
    exp_rd(MEM_TYPE_VRAM, 16'd16);
    exp_wr(16'd16, 8'h00);
    exp_rd(MEM_TYPE_VRAM, 16'd17);
    exp_wr(16'd17, 8'h00);
    exp_done(1'b1);
    start_draw(8'd3, 8'd2, 4'd1, 12'h210);
    wait_done(100);
    @(posedge clk); #1;
    obs("t3_coll_held", coll, 1);
    obs("t3_busy_idle", busy, 0);

    // 4: right and bottom clipping, then coordinate wrap of the origin
    exp_rd(MEM_TYPE_RAM, 16'h0220);
    exp_rd(MEM_TYPE_VRAM, 16'd255);
    exp_wr(16'd255, 8'h07);
    exp_done(1'b0);
    start_draw(8'd61, 8'd31, 4'd3, 12'h220);
    wait_done(100);
    exp_rd(MEM_TYPE_RAM, 16'h0230);
    exp_rd(MEM_TYPE_VRAM, 16'd8);
    exp_wr(16'd8, 8'h10);
    exp_rd(MEM_TYPE_VRAM, 16'd9);
    exp_wr(16'd9, 8'h20);
    exp_done(1'b0);
    start_draw(8'd67, 8'd33, 4'd1, 12'h230);
    wait_done(100);

    // 5: write held under backpressure, stray read response ignored
    exp_rd(MEM_TYPE_RAM, 16'h0240);
    exp_rd(MEM_TYPE_VRAM, 16'd34);
    exp_wr(16'd34, 8'hAA);
    exp_done(1'b0);
    start_draw(8'd16, 8'd4, 4'd1, 12'h240);
    wait_req(1'b0, MEM_TYPE_VRAM);
    @(posedge clk); #1;
    stall = 1'b1;
    wait_req(1'b1, MEM_TYPE_VRAM);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      stray = (k == 2);
      @(negedge clk);
      obs("t5_held", {5'd0, mv, mwe, mtype, maddr, mdata}, {5'd0, 3'b111, 16'd34, 8'hAA});
    end
    @(posedge clk); #1;
    stray = 1'b0;
    stall = 1'b0;
    wait_done(100);

    // 6: reset while waiting for the left VRAM read, then a clean redraw
    exp_rd(MEM_TYPE_RAM, 16'h0250);
    exp_rd(MEM_TYPE_VRAM, 16'd48);
    start_draw(8'd0, 8'd6, 4'd1, 12'h250);
    wait_req(1'b0, MEM_TYPE_VRAM);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    obs("t6_busy_after_rst", busy, 0);
    obs("t6_valid_after_rst", mv, 0);
    obs("t6_done_after_rst", done, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    exp_rd(MEM_TYPE_RAM, 16'h0250);
    exp_rd(MEM_TYPE_VRAM, 16'd48);
    exp_wr(16'd48, 8'hC3);
    exp_done(1'b0);
    start_draw(8'd0, 8'd6, 4'd1, 12'h250);
    wait_done(100);

    repeat (2) @(posedge clk);
    #1;
    obs("sb_drained", sb.size(), 0);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
